// File: rtl/irq_priority_arbiter_if.sv
// Bundle of CPU/peripheral-facing signals for irq_priority_arbiter.
// The master side drives IRQ lines, configuration and claim/complete; the slave side is the arbiter.
interface irq_priority_arbiter_if #(
   parameter int EXT_IRQ_COUNT = 4
);
   localparam int IDW = $clog2(EXT_IRQ_COUNT);

   logic [EXT_IRQ_COUNT-1:0] irqBus;
   logic                     cfgWe;
   logic [EXT_IRQ_COUNT-1:0] cfgMask;
   logic                     claimReq;
   logic                     completeReq;
   logic [IDW-1:0]           completeId;
   logic                     interrupt;
   logic                     claimValid;
   logic [IDW-1:0]           claimId;
   logic [EXT_IRQ_COUNT-1:0] pendingOut;

   modport master (
      output irqBus, cfgWe, cfgMask, claimReq, completeReq, completeId,
      input  interrupt, claimValid, claimId, pendingOut
   );

   modport slave (
      input  irqBus, cfgWe, cfgMask, claimReq, completeReq, completeId,
      output interrupt, claimValid, claimId, pendingOut
   );
endinterface

// File: rtl/irq_priority_arbiter.sv
// Edge-latching interrupt arbiter with claim/complete handshake and no nesting.
// Define IRQ_ROTATE_EN for round-robin winner selection; default is lowest-index-first.
module irq_priority_arbiter #(
   parameter  int EXT_IRQ_COUNT = 4,
   localparam int IDW           = $clog2(EXT_IRQ_COUNT)
) (
   input logic                  clk,
   input logic                  resetn,
   irq_priority_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      SERVICING
   } state_t;

   state_t                   state, state_next;
   logic [EXT_IRQ_COUNT-1:0] irq_prev;
   logic [EXT_IRQ_COUNT-1:0] pending, pending_next;
   logic [EXT_IRQ_COUNT-1:0] enable;
   logic [IDW-1:0]           active_id;
   logic [IDW-1:0]           claim_id;
   logic                     claim_valid;
   logic                     interrupt_q;
   logic                     claim_fire;
   logic [IDW-1:0]           winner;
   logic [EXT_IRQ_COUNT-1:0] req;
   logic [EXT_IRQ_COUNT-1:0] rise;

   assign req  = pending & enable;
   assign rise = bus.irqBus & ~irq_prev;

`ifdef IRQ_ROTATE_EN
   logic [IDW-1:0] last_grant;
   logic           found;

   // Search begins one past the previous grant and wraps around.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < EXT_IRQ_COUNT; k++) begin
         if (!found && req[IDW'((int'(last_grant) + 1 + k) % EXT_IRQ_COUNT)]) begin
            winner = IDW'((int'(last_grant) + 1 + k) % EXT_IRQ_COUNT);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant <= IDW'(EXT_IRQ_COUNT - 1);
      end else if (claim_fire) begin
         last_grant <= winner;
      end
   end
`else
   // Walking downward lets the lowest set index be the final assignment.
   always_comb begin
      winner = '0;
      for (int i = EXT_IRQ_COUNT - 1; i >= 0; i--) begin
         if (req[i]) winner = IDW'(i);
      end
   end
`endif

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      claim_fire = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req) state_next = PENDING;
         end
         PENDING: begin
            if (!(|req)) begin
               state_next = IDLE;
            end else if (bus.claimReq) begin
               state_next = SERVICING;
               claim_fire = 1'b1;
            end
         end
         SERVICING: begin
            if (bus.completeReq && (bus.completeId == active_id)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // A fresh edge on the claimed source re-latches it: set wins over clear.
      pending_next = pending;
      if (claim_fire) pending_next[winner] = 1'b0;
      pending_next = pending_next | rise;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         irq_prev    <= '0;
         pending     <= '0;
         enable      <= '0;
         active_id   <= '0;
         claim_id    <= '0;
         claim_valid <= 1'b0;
         interrupt_q <= 1'b0;
      end else begin
         state       <= state_next;
         irq_prev    <= bus.irqBus;
         pending     <= pending_next;
         claim_valid <= claim_fire;
         interrupt_q <= (state_next == PENDING);
         if (bus.cfgWe) enable <= bus.cfgMask;
         if (claim_fire) begin
            claim_id  <= winner;
            active_id <= winner;
         end
      end
   end

   assign bus.interrupt  = interrupt_q;
   assign bus.claimValid = claim_valid;
   assign bus.claimId    = claim_id;
   assign bus.pendingOut = pending;

endmodule

// File: doc/irq_priority_arbiter.md
IRQ_PRIORITY_ARBITER -- requirements
Module: irq_priority_arbiter

Interface
REQ-001 SHALL have parameter EXT_IRQ_COUNT, default 4, giving the number of external interrupt sources (legal 2..32).
REQ-002 SHALL have derived width IDW = $clog2(EXT_IRQ_COUNT), used for source IDs.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 irqBus  input  EXT_IRQ_COUNT  level interrupt lines from peripherals.
REQ-006 cfgWe  input  1  write strobe for the enable register.
REQ-007 cfgMask  input  EXT_IRQ_COUNT  new enable-register value, taken when cfgWe=1.
REQ-008 claimReq  input  1  CPU claims the highest-ranked enabled pending source.
REQ-009 completeReq  input  1  CPU signals end of service.
REQ-010 completeId  input  IDW  ID being completed.
REQ-011 interrupt  output  1  registered interrupt request to the CPU core.
REQ-012 claimValid  output  1  one-cycle pulse; claimId is valid.
REQ-013 claimId  output  IDW  claimed source ID, held until the next claim.
REQ-014 pendingOut  output  EXT_IRQ_COUNT  pending-register status.

Function
REQ-015 SHALL keep per-source registers irqPrev, pending and enable, plus activeId (IDW) and a state register with states IDLE, PENDING, SERVICING.
REQ-016 Pending set: pending[i] sets at an edge where irqBus[i]=1 and irqPrev[i]=0 (rising edge); irqPrev updates every cycle.
REQ-017 Pending latching is independent of enable; disabled sources latch pending but never assert interrupt.
REQ-018 IDLE->PENDING when (pending & enable)!=0; interrupt=1 from that edge.
- Latency: an irqBus rise sampled at edge E0 gives interrupt=1 after edge E1.
REQ-019 PENDING->IDLE, interrupt=0, when (pending & enable) becomes 0 (e.g. mask write) without a claim.
REQ-020 Claim in PENDING with claimReq=1:
- winner = lowest index set in (pending & enable)
- claimId<=winner, activeId<=winner, claimValid=1 for exactly one cycle
- pending[winner] cleared; state->SERVICING; interrupt=0.
REQ-021 claimReq in IDLE or SERVICING SHALL be ignored; claimValid stays 0.
REQ-022 Same-cycle rising edge on the source being claimed SHALL leave pending[winner]=1 (set wins over clear).
REQ-023 In SERVICING, completeReq=1 with completeId==activeId SHALL return the state to IDLE.
- Mismatched ID, or completeReq in any other state, is ignored.
REQ-024 No nesting: interrupt SHALL stay 0 throughout SERVICING regardless of new pending sources.
REQ-025 After completion, remaining enabled pending sources SHALL re-raise interrupt at the next edge (IDLE->PENDING rule).
REQ-026 cfgWe SHALL update enable at the edge in any state, and takes effect for evaluation in the following cycle.
REQ-027 pendingOut SHALL equal the pending register.

Reset
REQ-028 When resetn=0 at a clock edge, the block SHALL clear state to IDLE and set pending, enable, irqPrev, activeId, claimId, claimValid and interrupt to 0.
- Reset overrides all other inputs, including mid-SERVICING.
REQ-029 A line already high at reset release SHALL register as a rising edge on the first active cycle (irqPrev=0).

Configuration
REQ-030 Macro IRQ_ROTATE_EN defined: winner SHALL be round-robin.
- Search starts at (lastGrant+1) mod EXT_IRQ_COUNT.
- lastGrant resets to EXT_IRQ_COUNT-1, so the first search starts at 0.
- lastGrant is updated on each claim.
REQ-031 IRQ_ROTATE_EN undefined: fixed priority per REQ-020, and no lastGrant register exists.

Verification
REQ-032 enable=4'b1111, pulse irqBus[2] -> interrupt=1 two edges after the rise; claimReq -> claimValid pulse, claimId=2, pendingOut=0, interrupt=0.
REQ-033 irqBus[1] and irqBus[3] rise together with all enabled -> first claim gives ID 1; complete(1) -> interrupt re-asserts; second claim gives ID 3.
REQ-034 enable=4'b0000, irqBus[0] rises -> pendingOut=4'b0001, interrupt stays 0; write cfgMask=4'b0001 -> interrupt=1 one edge later.
REQ-035 In SERVICING of ID 2, completeReq with completeId=1 -> state and interrupt unchanged; completeId=2 -> IDLE.
REQ-036 resetn=0 during SERVICING with pending=4'b1010 -> all outputs 0 after one edge; a claimReq then yields no claimValid.
REQ-037 (IRQ_ROTATE_EN) all four sources pending, four claim/complete rounds with re-pulsed lines -> claimIds 0,1,2,3, then 0.
